// File: rtl/puf_eval_sequencer.sv
// Arbiter-PUF evaluation sequencer: LFSR challenges, launch pulses, 2-flop response sync, majority vote.
// Latency: NUM_BITS*(REPEATS*(SETTLE_CYC+PULSE_CYC+2)+2) cycles from start acceptance to resp_valid.
// Backpressure: resp_word/resp_valid/unstable_cnt held in HOLD until resp_ready; start ignored while busy.
module puf_eval_sequencer #(
  parameter int NUM_BITS   = 8,
  parameter int REPEATS    = 5,
  parameter int SETTLE_CYC = 4,
  parameter int PULSE_CYC  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          seed,
  output logic                busy,
  output logic [7:0]          puf_challenge,
  output logic                puf_pulse,
  input  logic                puf_response,
  output logic [NUM_BITS-1:0] resp_word,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [7:0]          unstable_cnt
);

  // Phase counter must index the longest timed state; RELAX always needs 2 cycles.
  localparam int PH_MAX1 = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
  localparam int PH_MAX  = (PH_MAX1 > 2) ? PH_MAX1 : 2;
  localparam int PH_W    = $clog2(PH_MAX);
  localparam int BIT_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_FIRE, S_RELAX, S_VOTE, S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [7:0]          chal_q, chal_d;
  logic                pulse_q, pulse_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [NUM_BITS-1:0] word_q, word_d;
  logic [7:0]          unst_q, unst_d;
  logic [3:0]          rep_q, rep_d;
  logic [3:0]          ones_q, ones_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                sync1_q, sync2_q;

  logic                vote_bit;
  logic                vote_unstable;
  logic [7:0]          lfsr_step;

  assign vote_bit      = (ones_q > 4'(REPEATS / 2));
  assign vote_unstable = (ones_q != 4'd0) && (ones_q != 4'(REPEATS));
  assign lfsr_step     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Next-state and registered-output computation for the evaluation sequence.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    chal_d  = chal_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    word_d  = word_q;
    unst_d  = unst_q;
    rep_d   = rep_q;
    ones_d  = ones_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
          // An all-zero LFSR would never leave zero.
          lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
          unst_d  = 8'd0;
          word_d  = '0;
          bit_d   = '0;
        end
      end
      S_LOAD: begin
        chal_d  = lfsr_q;
        rep_d   = 4'd0;
        ones_d  = 4'd0;
        phase_d = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (phase_q == PH_W'(SETTLE_CYC - 1)) begin
          phase_d = '0;
          pulse_d = 1'b1;
          state_d = S_FIRE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_FIRE: begin
        if (phase_q == PH_W'(PULSE_CYC - 1)) begin
          phase_d = '0;
          pulse_d = 1'b0;
          state_d = S_RELAX;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_RELAX: begin
        // Second RELAX cycle: the synchronised arbiter result has settled.
        if (phase_q == PH_W'(1)) begin
          phase_d = '0;
          ones_d  = ones_q + {3'd0, sync2_q};
          rep_d   = rep_q + 4'd1;
          if (({1'b0, rep_q} + 5'd1) < 5'(REPEATS)) begin
            state_d = S_SETTLE;
          end else begin
            state_d = S_VOTE;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_VOTE: begin
        word_d = NUM_BITS'({word_q, vote_bit});
        if (vote_unstable && (unst_q != 8'hFF)) begin
          unst_d = unst_q + 8'd1;
        end
        lfsr_d = lfsr_step;
        if (bit_q == BIT_W'(NUM_BITS - 1)) begin
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else begin
          bit_d   = bit_q + BIT_W'(1);
          state_d = S_LOAD;
        end
      end
      S_HOLD: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register with async reset; also hosts the response synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= 8'd0;
      chal_q  <= 8'd0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      word_q  <= '0;
      unst_q  <= 8'd0;
      rep_q   <= 4'd0;
      ones_q  <= 4'd0;
      phase_q <= '0;
      bit_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      chal_q  <= chal_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      unst_q  <= unst_d;
      rep_q   <= rep_d;
      ones_q  <= ones_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sync1_q <= puf_response;
      sync2_q <= sync1_q;
    end
  end

  assign busy          = busy_q;
  assign puf_challenge = chal_q;
  assign puf_pulse     = pulse_q;
  assign resp_word     = word_q;
  assign resp_valid    = valid_q;
  assign unstable_cnt  = unst_q;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Bench for puf_eval_sequencer: behavioural PUF model, table of runs, reset-in-FIRE sequence.
// Latency: expects resp_valid NUM_BITS*(REPEATS*E+2) cycles after start acceptance.
// Backpressure: holds resp_ready low for a per-row number of cycles and checks outputs stay put.
module tb_puf_eval_sequencer;

  localparam int NB  = 8;
  localparam int RP  = 5;
  localparam int SC  = 4;
  localparam int PC  = 2;
  localparam int LAT = NB * (RP * (SC + PC + 2) + 2);

  localparam int M_ZERO  = 0;
  localparam int M_ONE   = 1;
  localparam int M_CHAL0 = 2;
  localparam int M_FLIP2 = 3;
  localparam int M_RAND  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    seed;
  logic          busy;
  logic [7:0]    puf_challenge;
  logic          puf_pulse;
  logic          puf_response;
  logic [NB-1:0] resp_word;
  logic          resp_valid;
  logic          resp_ready;
  logic [7:0]    unstable_cnt;

  puf_eval_sequencer #(
    .NUM_BITS(NB), .REPEATS(RP), .SETTLE_CYC(SC), .PULSE_CYC(PC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .busy(busy),
    .puf_challenge(puf_challenge), .puf_pulse(puf_pulse), .puf_response(puf_response),
    .resp_word(resp_word), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .unstable_cnt(unstable_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lstep(input logic [7:0] c);
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

  // PUF model and protocol monitor: one response per launch, recorded with its challenge.
  int         mode = M_ZERO;
  int         resp_q[$];
  logic [7:0] chal_q[$];
  int         pulse_cnt  = 0;
  int         width_err  = 0;
  int         chg_err    = 0;
  int         high_len   = 0;
  logic       pulse_prev = 1'b0;
  logic [7:0] chal_at_rise = 8'd0;
  int         r_v, idx_v, base_v;

  always @(negedge clk) begin
    if (rst) begin
      pulse_prev   = 1'b0;
      high_len     = 0;
      puf_response = 1'b0;
    end else begin
      if (puf_pulse && !pulse_prev) begin
        idx_v = resp_q.size();
        case (mode)
          M_ZERO:  r_v = 0;
          M_ONE:   r_v = 1;
          M_CHAL0: r_v = int'(puf_challenge[0]);
          M_FLIP2: r_v = ((idx_v % RP) == 1) ? 0 : 1;
          default: begin
            if ((idx_v % RP) == 0) base_v = int'($urandom_range(0, 1));
            r_v = ($urandom_range(0, 3) == 0) ? 1 - base_v : base_v;
          end
        endcase
        resp_q.push_back(r_v);
        chal_q.push_back(puf_challenge);
        chal_at_rise = puf_challenge;
        puf_response = r_v[0];
        pulse_cnt++;
        high_len = 0;
      end
      if (puf_pulse) begin
        high_len++;
        if (puf_challenge !== chal_at_rise) chg_err++;
      end else if (pulse_prev && high_len != PC) begin
        width_err++;
      end
      pulse_prev = puf_pulse;
    end
  end

  typedef struct {
    logic [7:0]  seed;
    int          mode;
    int          hold;
    bit          known;
    logic [31:0] word;
    logic [31:0] unst;
  } vec_t;

  vec_t vecs[8];

  task automatic run_row(input vec_t v, input int row);
    int          acc, lat, ones, unst, n_bad, n_hold, idx;
    bit          seen;
    logic [31:0] mw, ew, eu;
    logic [7:0]  c;
    logic [NB-1:0] w0;
    logic [7:0]  u0;
    @(negedge clk);
    mode = v.mode;
    resp_q.delete();
    chal_q.delete();
    pulse_cnt = 0; width_err = 0; chg_err = 0;
    seed = v.seed; start = 1'b1; resp_ready = (v.hold == 0);
    @(negedge clk);
    start = 1'b0;
    seed  = 8'($urandom);
    acc   = cyc;
    check($sformatf("row%0d busy_after_start", row), busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 4 * LAT; i++) begin
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      start = ((i % 37) == 5);   // must be ignored while busy
      seed  = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      checks++; failures++;
      $display("FAIL row%0d resp_valid_timeout actual=never required=%0d cycles", row, LAT);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      return;
    end
    lat = cyc - acc;
    check($sformatf("row%0d latency", row), lat, LAT);
    check($sformatf("row%0d pulse_count", row), pulse_cnt, NB * RP);
    check($sformatf("row%0d pulse_width_errors", row), width_err, 0);
    check($sformatf("row%0d chal_change_in_pulse", row), chg_err, 0);

    // Reference: majority over each group of REPEATS responses, first bit ends up at MSB.
    mw = 0; unst = 0;
    for (int b = 0; b < NB; b++) begin
      ones = 0;
      for (int r = 0; r < RP; r++) begin
        idx = b * RP + r;
        if (idx < resp_q.size()) ones += resp_q[idx];
      end
      mw = (mw << 1) | ((2 * ones > RP) ? 1 : 0);
      if (ones != 0 && ones != RP && unst < 255) unst++;
    end
    ew = v.known ? v.word : mw;
    eu = v.known ? v.unst : unst;
    check($sformatf("row%0d resp_word", row), resp_word, ew);
    check($sformatf("row%0d unstable_cnt", row), unstable_cnt, eu);

    c = (v.seed == 8'h00) ? 8'h01 : v.seed;
    if (chal_q.size() > 0) check($sformatf("row%0d first_challenge", row), chal_q[0], c);
    n_bad = 0;
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < RP; r++) begin
        idx = b * RP + r;
        if (idx >= chal_q.size() || chal_q[idx] !== c) n_bad++;
      end
      c = lstep(c);
    end
    check($sformatf("row%0d challenge_seq_errors", row), n_bad, 0);

    if (v.hold > 0) begin
      w0 = resp_word; u0 = unstable_cnt; n_hold = 0;
      for (int h = 0; h < v.hold; h++) begin
        start = ((h % 3) == 0);
        seed  = 8'($urandom);
        @(negedge clk);
        if (resp_valid !== 1'b1 || busy !== 1'b1 || resp_word !== w0 || unstable_cnt !== u0) n_hold++;
      end
      check($sformatf("row%0d hold_stable_errors", row), n_hold, 0);
      start = 1'b0;
      resp_ready = 1'b1;
    end
    @(negedge clk);
    check($sformatf("row%0d valid_after_ready", row), resp_valid, 0);
    check($sformatf("row%0d busy_after_ready", row), busy, 0);
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check($sformatf("row%0d no_queued_start", row), {busy, puf_pulse}, 2'b00);
  endtask

  initial begin
    bit got_pulse;
    rst = 1'b1; start = 1'b0; seed = 8'h00; resp_ready = 1'b0;

    // Expected words follow the tap set c7^c5^c4^c3; e.g. 0x11 steps to 0x23.
    vecs[0] = '{8'h01, M_ONE,   0,  1'b1, 32'hFF, 32'd0};
    vecs[1] = '{8'h00, M_CHAL0, 0,  1'b1, 32'h8E, 32'd0};
    vecs[2] = '{8'h5A, M_FLIP2, 0,  1'b1, 32'hFF, 32'd8};
    vecs[3] = '{8'h3C, M_ZERO,  20, 1'b1, 32'h00, 32'd0};
    for (int i = 4; i < 8; i++) begin
      vecs[i] = '{8'($urandom_range(0, 255)), M_RAND, int'($urandom_range(0, 6)), 1'b0, 32'd0, 32'd0};
    end

    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset puf_pulse", puf_pulse, 0);
    check("reset resp_valid", resp_valid, 0);
    check("reset resp_word", resp_word, 0);
    check("reset unstable_cnt", unstable_cnt, 0);
    check("reset puf_challenge", puf_challenge, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a launch pulse.
    mode = M_ONE; seed = 8'h77; start = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_pulse = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (puf_pulse) begin
        got_pulse = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("midrun pulse_seen", got_pulse, 1);
    rst = 1'b1;
    #1;
    check("midrun_rst puf_pulse", puf_pulse, 0);
    check("midrun_rst busy", busy, 0);
    check("midrun_rst resp_valid", resp_valid, 0);
    check("midrun_rst puf_challenge", puf_challenge, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("after_rst idle", {busy, puf_pulse, resp_valid}, 3'b000);

    for (int i = 0; i < 8; i++) run_row(vecs[i], i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
